// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared defaults and types for the register-file write-port arbiter.
// Default widths/depths fall back here when the project constants are not already defined.
`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif
`ifndef REG_ADDR_WIDTH
`define REG_ADDR_WIDTH 5
`endif
`ifndef WB_FIFO_DEPTH
`define WB_FIFO_DEPTH 4
`endif
`ifndef WB_STARVE_LIMIT
`define WB_STARVE_LIMIT 8
`endif

package regfile_wb_arbiter_pkg;

    typedef enum logic [1:0] {
        SRC_NONE,
        SRC_PIPE,
        SRC_FIFO,
        SRC_BYPASS
    } wb_src_t;

    // Occupancy counter must represent 0..depth inclusive.
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO buffering multi-cycle results ({addr,data}) for the write port.
// Push on full and pop on empty are ignored.
module wb_fifo
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int WIDTH = 37,
    parameter int DEPTH = 4,
    localparam int CW   = cnt_width(DEPTH),
    localparam int PW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);

    logic [DEPTH-1:0][WIDTH-1:0] mem;
    logic [PW-1:0]               rd_ptr, wr_ptr;
    logic                        do_push, do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // Storage needs no reset: pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register file's single write port between the pipeline writeback (priority)
// and buffered multi-cycle results. Define WB_BYPASS_EN for zero-latency writes when idle.
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int WORD_WIDTH   = `WORD_WIDTH,
    parameter int ADDR_WIDTH   = `REG_ADDR_WIDTH,
    parameter int FIFO_DEPTH   = `WB_FIFO_DEPTH,
    parameter int STARVE_LIMIT = `WB_STARVE_LIMIT,
    localparam int CW          = cnt_width(FIFO_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  pipe_valid,
    input  logic [ADDR_WIDTH-1:0] pipe_addr,
    input  logic [WORD_WIDTH-1:0] pipe_data,
    input  logic                  mc_valid,
    output logic                  mc_ready,
    input  logic [ADDR_WIDTH-1:0] mc_addr,
    input  logic [WORD_WIDTH-1:0] mc_data,
    output logic                  rf_w_en,
    output logic [ADDR_WIDTH-1:0] rf_wa3,
    output logic [WORD_WIDTH-1:0] rf_wd3,
    output logic                  pipe_stall_req,
    output logic [CW-1:0]         fifo_count
);

    localparam int EW = ADDR_WIDTH + WORD_WIDTH;
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    logic [EW-1:0] head;
    logic          full, empty, push, pop, pipe_win, bypass;
    logic [SW-1:0] starve_cnt, starve_nxt;
    wb_src_t       src;

    // Writes to x0 are discarded, so such a pipe slot is free for the FIFO.
    assign pipe_win = pipe_valid && (pipe_addr != '0);
    assign mc_ready = rst_n && !full;

`ifdef WB_BYPASS_EN
    assign bypass = !pipe_win && empty && mc_valid && (mc_addr != '0);
`else
    assign bypass = 1'b0;
`endif

    assign pop  = !pipe_win && !empty;
    assign push = mc_valid && mc_ready && (mc_addr != '0) && !bypass;

    wb_fifo #(.WIDTH(EW), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .din   ({mc_addr, mc_data}),
        .dout  (head),
        .count (fifo_count),
        .full  (full),
        .empty (empty)
    );

    always_comb begin
        src = SRC_NONE;
        if (!rst_n)        src = SRC_NONE;
        else if (pipe_win) src = SRC_PIPE;
        else if (!empty)   src = SRC_FIFO;
        else if (bypass)   src = SRC_BYPASS;

        rf_w_en = 1'b0;
        rf_wa3  = '0;
        rf_wd3  = '0;
        case (src)
            SRC_PIPE:   begin rf_w_en = 1'b1; rf_wa3 = pipe_addr;             rf_wd3 = pipe_data;             end
            SRC_FIFO:   begin rf_w_en = 1'b1; rf_wa3 = head[EW-1:WORD_WIDTH]; rf_wd3 = head[WORD_WIDTH-1:0]; end
            SRC_BYPASS: begin rf_w_en = 1'b1; rf_wa3 = mc_addr;               rf_wd3 = mc_data;               end
            default:    ;
        endcase
    end

    always_comb begin
        starve_nxt = starve_cnt;
        if (empty || pop)                      starve_nxt = '0;
        else if (starve_cnt != SW'(STARVE_LIMIT)) starve_nxt = starve_cnt + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt     <= '0;
            pipe_stall_req <= 1'b0;
        end else begin
            starve_cnt     <= starve_nxt;
            pipe_stall_req <= (starve_nxt == SW'(STARVE_LIMIT));
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed self-checking bench for regfile_wb_arbiter (default depth 4, starve limit 8).
module tb_regfile_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pipe_valid = 1'b0;
    logic [4:0]  pipe_addr = '0;
    logic [31:0] pipe_data = '0;
    logic        mc_valid = 1'b0;
    logic        mc_ready;
    logic [4:0]  mc_addr = '0;
    logic [31:0] mc_data = '0;
    logic        rf_w_en;
    logic [4:0]  rf_wa3;
    logic [31:0] rf_wd3;
    logic        pipe_stall_req;
    logic [2:0]  fifo_count;

    int errs = 0;
    int checks = 0;

    regfile_wb_arbiter dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .pipe_valid     (pipe_valid),
        .pipe_addr      (pipe_addr),
        .pipe_data      (pipe_data),
        .mc_valid       (mc_valid),
        .mc_ready       (mc_ready),
        .mc_addr        (mc_addr),
        .mc_data        (mc_data),
        .rf_w_en        (rf_w_en),
        .rf_wa3         (rf_wa3),
        .rf_wd3         (rf_wd3),
        .pipe_stall_req (pipe_stall_req),
        .fifo_count     (fifo_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wr(input string tag, input logic en, input logic [4:0] a, input logic [31:0] d);
        chk({tag, ".w_en"}, 64'(rf_w_en), 64'(en));
        chk({tag, ".wa3"},  64'(rf_wa3),  64'(a));
        chk({tag, ".wd3"},  64'(rf_wd3),  64'(d));
    endtask

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // reset with a live pipe write: port must stay quiet
        pipe_valid = 1'b1; pipe_addr = 5'd5; pipe_data = 32'hDEADBEEF;
        #2;
        wr("rst", 1'b0, 5'd0, 32'h0);
        chk("rst.ready", 64'(mc_ready), 64'd0);
        chk("rst.count", 64'(fifo_count), 64'd0);
        chk("rst.stall", 64'(pipe_stall_req), 64'd0);
        pipe_valid = 1'b0;
        cyc; cyc;
        rst_n = 1'b1;

        // pipe-only writes
        pipe_valid = 1'b1; pipe_addr = 5'd5; pipe_data = 32'hDEADBEEF;
        #1;
        wr("pipe.x5", 1'b1, 5'd5, 32'hDEADBEEF);
        chk("pipe.x5.ready", 64'(mc_ready), 64'd1);
        cyc;
        pipe_addr = 5'd0; pipe_data = 32'h1;
        #1;
        wr("pipe.x0", 1'b0, 5'd0, 32'h0);
        chk("pipe.x0.ready", 64'(mc_ready), 64'd1);
        cyc;

        // single mc result with idle pipe
        pipe_valid = 1'b0;
        mc_valid = 1'b1; mc_addr = 5'd7; mc_data = 32'h11;
        #1;
`ifdef WB_BYPASS_EN
        wr("mc.x7.same", 1'b1, 5'd7, 32'h11);
        cyc;
        mc_valid = 1'b0;
        #1;
        chk("mc.x7.count", 64'(fifo_count), 64'd0);
        wr("mc.x7.after", 1'b0, 5'd0, 32'h0);
`else
        wr("mc.x7.same", 1'b0, 5'd0, 32'h0);
        cyc;
        mc_valid = 1'b0;
        #1;
        chk("mc.x7.count1", 64'(fifo_count), 64'd1);
        wr("mc.x7.next", 1'b1, 5'd7, 32'h11);
        cyc;
        #1;
        chk("mc.x7.count0", 64'(fifo_count), 64'd0);
        wr("mc.x7.after", 1'b0, 5'd0, 32'h0);
`endif
        cyc;

        // pipe busy every cycle, fill FIFO with x1..x4
        pipe_valid = 1'b1; pipe_addr = 5'd9; pipe_data = 32'h99;
        for (int i = 1; i <= 4; i++) begin
            mc_valid = 1'b1; mc_addr = 5'(i); mc_data = 32'h100 + 32'(i);
            #1;
            chk("fill.count", 64'(fifo_count), 64'(i - 1));
            cyc;
        end
        mc_valid = 1'b0;
        #1;
        chk("full.count", 64'(fifo_count), 64'd4);
        chk("full.ready", 64'(mc_ready), 64'd0);
        wr("full.pipe", 1'b1, 5'd9, 32'h99);
        for (int k = 0; k < 4; k++) cyc;
        chk("starve.7", 64'(pipe_stall_req), 64'd0);
        cyc;
        chk("starve.8", 64'(pipe_stall_req), 64'd1);
        cyc;
        chk("starve.sat", 64'(pipe_stall_req), 64'd1);
        chk("starve.count", 64'(fifo_count), 64'd4);

        // one bubble drains x1
        pipe_valid = 1'b0;
        #1;
        wr("bubble.x1", 1'b1, 5'd1, 32'h101);
        cyc;

        // refill to full with x5 while pipe busy
        pipe_valid = 1'b1;
        mc_valid = 1'b1; mc_addr = 5'd5; mc_data = 32'h105;
        #1;
        chk("bubble.count", 64'(fifo_count), 64'd3);
        chk("bubble.stall", 64'(pipe_stall_req), 64'd0);
        cyc;

        // full, pipe idle, mc holds x6
        pipe_valid = 1'b0;
        mc_addr = 5'd6; mc_data = 32'h106;
        #1;
        chk("drain.full", 64'(fifo_count), 64'd4);
        chk("drain.ready0", 64'(mc_ready), 64'd0);
        wr("drain.x2", 1'b1, 5'd2, 32'h102);
        cyc;
        #1;
        chk("drain.count3", 64'(fifo_count), 64'd3);
        chk("drain.ready1", 64'(mc_ready), 64'd1);
        wr("drain.x3", 1'b1, 5'd3, 32'h103);
        cyc;
        mc_valid = 1'b0;
        #1;
        chk("drain.pushpop", 64'(fifo_count), 64'd3);
        wr("drain.x4", 1'b1, 5'd4, 32'h104);
        cyc;
        #1;
        wr("drain.x5", 1'b1, 5'd5, 32'h105);
        chk("drain.count2", 64'(fifo_count), 64'd2);
        cyc;
        #1;
        wr("drain.x6", 1'b1, 5'd6, 32'h106);
        cyc;
        #1;
        wr("drain.idle", 1'b0, 5'd0, 32'h0);
        chk("drain.count0", 64'(fifo_count), 64'd0);
        chk("drain.stall", 64'(pipe_stall_req), 64'd0);
        cyc;

        // mc write to x0 is accepted and dropped
        mc_valid = 1'b1; mc_addr = 5'd0; mc_data = 32'hFF;
        #1;
        wr("x0.same", 1'b0, 5'd0, 32'h0);
        chk("x0.ready", 64'(mc_ready), 64'd1);
        cyc;
        mc_valid = 1'b0;
        #1;
        chk("x0.count", 64'(fifo_count), 64'd0);
        wr("x0.after", 1'b0, 5'd0, 32'h0);
        cyc;

        // queue three, then reset mid-cycle
        pipe_valid = 1'b1; pipe_addr = 5'd9; pipe_data = 32'h99;
        for (int i = 10; i <= 12; i++) begin
            mc_valid = 1'b1; mc_addr = 5'(i); mc_data = 32'(i);
            cyc;
        end
        mc_valid = 1'b0;
        #1;
        chk("rst2.pre", 64'(fifo_count), 64'd3);
        #2;
        rst_n = 1'b0;
        #1;
        wr("rst2.async", 1'b0, 5'd0, 32'h0);
        chk("rst2.ready", 64'(mc_ready), 64'd0);
        chk("rst2.count", 64'(fifo_count), 64'd0);
        chk("rst2.stall", 64'(pipe_stall_req), 64'd0);
        pipe_valid = 1'b0;
        cyc; cyc;
        rst_n = 1'b1;
        #1;
        chk("rst2.rel.count", 64'(fifo_count), 64'd0);
        chk("rst2.rel.ready", 64'(mc_ready), 64'd1);
        wr("rst2.rel", 1'b0, 5'd0, 32'h0);
        cyc;
        #1;
        wr("rst2.later", 1'b0, 5'd0, 32'h0);
        chk("rst2.later.count", 64'(fifo_count), 64'd0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
Write-port controller for the processor's single-write-port register file. It shares the port between two sources:
- the in-order pipeline writeback stage: priority source, no backpressure;
- a multi-cycle unit (load/mul/div result path) using a valid/ready handshake, buffered in a small FIFO.

It drives the register file's w_en/wa3/wd3 directly. It also raises a starvation request so the pipeline inserts a bubble when buffered results wait too long.

Parameters:
WORD_WIDTH, `WORD_WIDTH (32), data width
ADDR_WIDTH, `REG_ADDR_WIDTH (5), register address width
FIFO_DEPTH, 4, multi-cycle result buffer entries; power of 2, >=2
STARVE_LIMIT, 8, cycles FIFO head may wait before pipe_stall_req asserts

Ports:
clk  in  1  clock, all state on posedge
rst_n  in  1  asynchronous active-low reset
pipe_valid  in  1  pipeline writeback valid
pipe_addr  in  ADDR_WIDTH  pipeline destination register
pipe_data  in  WORD_WIDTH  pipeline result
mc_valid  in  1  multi-cycle result valid
mc_ready  out  1  arbiter can accept multi-cycle result
mc_addr  in  ADDR_WIDTH  multi-cycle destination register
mc_data  in  WORD_WIDTH  multi-cycle result
rf_w_en  out  1  register file write enable
rf_wa3  out  ADDR_WIDTH  register file write address
rf_wd3  out  WORD_WIDTH  register file write data
pipe_stall_req  out  1  request pipeline bubble next cycle
fifo_count  out  clog2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (rst_n low, async): FIFO emptied and contents discarded, fifo_count=0, starvation counter=0, rf_w_en=0, rf_wa3=0, rf_wd3=0, pipe_stall_req=0, mc_ready=0. A reset mid-operation loses buffered results without writing them.
- Port selection each cycle (combinational from state and pipe inputs), first match wins:
  1. pipe_valid && pipe_addr!=0: drive pipe_addr/pipe_data, rf_w_en=1.
  2. FIFO non-empty: drive head, rf_w_en=1, pop at posedge.
  3. Otherwise: rf_w_en=0, rf_wa3=0, rf_wd3=0.
- pipe_valid with pipe_addr==0 counts as an idle slot; the FIFO may drain in that cycle.
- mc_ready = rst_n && (fifo_count < FIFO_DEPTH). It does not depend on a same-cycle pop: when full, ready stays 0 even if the head is popping.
- Accept: mc_valid && mc_ready at posedge.
  - mc_addr!=0: enqueue.
  - mc_addr==0: accept and discard; no enqueue, no write.
- Simultaneous push and pop: count unchanged, FIFO order preserved.
- Latency without bypass: a result accepted at edge N reaches the write port no earlier than the cycle after edge N. It lands at edge N+1 when the pipe is idle.
- Starvation counter:
  - increments each cycle the FIFO is non-empty and the head is not popped;
  - clears on a pop or when the FIFO is empty;
  - saturates at STARVE_LIMIT.
- pipe_stall_req is registered: 1 while counter==STARVE_LIMIT. The pipeline responds by deasserting pipe_valid. If pipe_valid stays 1, the pipe still wins.
- Ordering: FIFO is strict in-order. Cross-source WAW hazards to the same register are the issue logic's responsibility; the arbiter does no address comparison.
- fifo_count range 0..FIFO_DEPTH. Pointers wrap modulo FIFO_DEPTH.

Optional Feature:
Macro: WB_BYPASS_EN.
- Defined: when the FIFO is empty, the pipe slot is idle, and mc_valid && mc_addr!=0, the result is written to the port in the same cycle (rf_w_en=1, mc_addr/mc_data) and is not enqueued. Zero-cycle latency.
- Undefined: every multi-cycle result passes through the FIFO, minimum 1-cycle latency.
- Port list is identical in both builds.

Decomposition:
- constants.vh gains WB_FIFO_DEPTH and WB_STARVE_LIMIT defaults, alongside the existing WORD_WIDTH and REG_ADDR_WIDTH.
- One sub-module: wb_fifo, a synchronous FIFO with async active-low reset.
  - Ports: push, pop, din {addr,data}, dout, count, full, empty.
  - Width ADDR_WIDTH+WORD_WIDTH.
- The arbiter holds the selection mux and starvation counter.

Test Plan:
- Pipe-only writes x5=0xDEADBEEF then x0=0x1 -> rf_w_en=1 with wa3=5 and wd3=0xDEADBEEF, then rf_w_en=0; mc_ready=1 throughout.
- Pipe idle, mc sends x7=0x11 -> bypass off: write at next cycle, fifo_count 1->0. Bypass on: write in same cycle, fifo_count stays 0.
- Pipe valid every cycle; mc pushes x1..x4 -> fifo_count=4, mc_ready=0. pipe_stall_req=1 eight cycles after the first enqueue. One pipe bubble pops x1; counter clears.
- FIFO full, pipe idle, mc_valid held -> pop x1, mc_ready stays 0 that cycle and accepts the next cycle; FIFO order x2,x3,x4,x5 verified.
- mc sends x0=0xFF -> accepted, fifo_count unchanged, no write.
- Three entries queued, rst_n pulsed low mid-cycle -> outputs zero immediately; after release fifo_count=0 and no writes of queued data.
